// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Each step forms a trial subtraction as A + ~B + 1 and uses the carry-out
// as the "no borrow" flag (the same adder path used for addition).
// Optional build macro SIGNED_DIV_EN: two's-complement operands, handled by
// taking magnitudes at capture and sign-correcting the results on the DONE load.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH:0]   rem_reg;        // partial remainder R (one guard bit)
    logic [WIDTH-1:0] q_reg;          // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs_reg;        // captured divisor (magnitude)
    logic [CW-1:0]    cnt_reg;        // steps completed in RUN
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dz_reg;

`ifdef SIGNED_DIV_EN
    logic             q_neg_reg;      // quotient must be negated on load
    logic             r_neg_reg;      // remainder must be negated on load
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract
    // via complement-add, keep the difference only when no borrow occurred.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] q_step;
    logic             last_step;

    assign shifted   = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign trial     = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_reg}} + (WIDTH+2)'(1);
    assign no_borrow = trial[WIDTH+1];
    assign rem_step  = no_borrow ? trial[WIDTH:0] : shifted;
    assign q_step    = {q_reg[WIDTH-2:0], no_borrow};
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    // Operand magnitudes at capture and sign-corrected results at the final step
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

    always_comb begin
`ifdef SIGNED_DIV_EN
        // The most negative value negates to itself, which as an unsigned
        // magnitude is exactly right, so the overflow case needs no special path.
        dvd_mag    = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
        dvs_mag    = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
        quot_final = q_neg_reg ? (~q_step + WIDTH'(1)) : q_step;
        rem_final  = r_neg_reg ? (~rem_step[WIDTH-1:0] + WIDTH'(1)) : rem_step[WIDTH-1:0];
`else
        dvd_mag    = dividend;
        dvs_mag    = divisor;
        quot_final = q_step;
        rem_final  = rem_step[WIDTH-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: divide-by-zero bypasses RUN, DONE always lasts one cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture on accepted start, iterate in RUN, load results on the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg       <= '0;
            q_reg         <= '0;
            dvs_reg       <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
`ifdef SIGNED_DIV_EN
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            dz_reg        <= 1'b1;
                        end else begin
                            rem_reg <= '0;
                            q_reg   <= dvd_mag;
                            dvs_reg <= dvs_mag;
                            cnt_reg <= '0;
                            dz_reg  <= 1'b0;
`ifdef SIGNED_DIV_EN
                            q_neg_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_neg_reg <= dividend[WIDTH-1];
`endif
                        end
                    end
                end
                RUN: begin
                    rem_reg <= rem_step;
                    q_reg   <= q_step;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_step) begin
                        quotient_reg  <= quot_final;
                        remainder_reg <= rem_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider for the calculator datapath. It is the inverse operation of the adder path: each step computes a trial subtraction as A + ~B + 1 (adder with Cin=1) and uses the carry-out as the "no borrow" flag. The block accepts operands on a start pulse, iterates one quotient bit per clock, and returns quotient and remainder with a one-cycle done pulse to the calculator control FSM.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request pulse; sampled only in IDLE
dividend  input  WIDTH  numerator; captured on accepted start
divisor  input  WIDTH  denominator; captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  registered flag, set when the captured divisor was 0

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; busy=0; done=0; quotient=0; remainder=0; div_by_zero=0.
  - Internal step counter and partial remainder are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, divisor!=0:
  - Capture the operands.
  - Partial remainder R (WIDTH+1 bits) is set to 0; shift register Q is set to dividend.
  - Counter is set to 0; div_by_zero is cleared.
  - Go to RUN.
- IDLE, start=1, divisor==0:
  - quotient={WIDTH{1}}; remainder=dividend; div_by_zero=1.
  - Go to DONE, so done is asserted 1 cycle after the start edge.
- RUN, one step per clock:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, divisor}, computed as addition of the complement with carry-in 1.
  - If carry-out=1 (no borrow): R=T. Otherwise R keeps the shifted value (restore).
  - Q shifts left, and the new LSB is the carry-out.
  - Counter increments.
  - After WIDTH steps, load quotient=Q and remainder=R[WIDTH-1:0], then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE unconditionally.
- Latency: done is asserted WIDTH+1 clocks after the accepting edge (9 for WIDTH=8).
- quotient, remainder and div_by_zero hold their values until the next accepted start. Stale values persist through IDLE.
- start while busy (RUN or DONE) is ignored and not queued. Operand changes during RUN have no effect.
- start held high continuously: one division is accepted per IDLE visit. Back-to-back throughput is one result per WIDTH+2 cycles.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is produced.
- dividend < divisor: quotient=0, remainder=dividend.
- divisor=1: quotient=dividend, remainder=0.
- Invariant for divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
Macro SIGNED_DIV_EN
- Defined:
  - Operands are two's complement.
  - Magnitudes are taken at capture, the unsigned core runs, and the results are sign-corrected in the DONE load.
  - Quotient sign is sign(dividend) XOR sign(divisor), truncated toward zero. Remainder sign follows the dividend.
  - Overflow case (most negative value / -1): quotient=most negative value (wraps), remainder=0, div_by_zero=0.
  - Divide by zero: quotient={WIDTH{1}} (-1), remainder=dividend.
  - Latency is unchanged (WIDTH+1).
- Undefined: purely unsigned operation as above. No sign logic is synthesized.

Test Plan:
1. WIDTH=8, 200/7 -> done at +9 clocks, quotient=28, remainder=4, div_by_zero=0, busy high for 9 cycles.
2. 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5.
3. 100/0 -> done at +1 clock, quotient=255, remainder=100, div_by_zero=1. A following 10/3 clears the flag: quotient=3, remainder=1.
4. Start 200/7, then pulse start with 50/5 at +3 -> second request ignored, result 28 r4. Start held high for 30 cycles -> done pulses every 10 cycles.
5. Start 200/7, assert rst at +4 -> all outputs 0 immediately, no done. After release, 81/9 -> quotient=9, remainder=0.
6. With SIGNED_DIV_EN: -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2); -128/-1 -> quotient=0x80, remainder=0. Exhaustive 256x255 sweep checks the invariant in both builds.
